// File: rtl/wb_queue.sv
// Write-back buffer: an in-order FIFO of (index, data) register writes that
// drains into the register-file write port whenever the pipeline leaves it idle.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_idx,
  input  logic [31:0] in_data,
  input  logic        pipe_we,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  input  logic [4:0]  q_ra1,
  input  logic [4:0]  q_ra2,
  output logic        pend1,
  output logic        pend2
);

  localparam int AW = $clog2(DEPTH);

  logic [4:0]       idx_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [AW:0]      count_q, count_d;
  logic [DEPTH-1:0] live;
  logic             enq, enq_store, drain, not_empty;

  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q != (AW+1)'(DEPTH));
  assign enq       = in_valid && in_ready;
  // Writes to x0 are accepted but never stored.
  assign enq_store = enq && (in_idx != 5'd0);
  assign drain     = not_empty && !pipe_we;

  assign rf_we = drain;
  assign rf_wa = not_empty ? idx_q[head_q]  : 5'd0;
  assign rf_wd = not_empty ? data_q[head_q] : 32'd0;

  // NOTE: every signal assigned in a combinational block gets a default first,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq_store) tail_d = tail_q + AW'(1);
    if (drain)     head_d = head_q + AW'(1);
    case ({enq_store, drain})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live[i] = {1'b0, AW'(i) - head_q} < count_q;
    end
  end

  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && (idx_q[i] == q_ra1)) pend1 = 1'b1;
      if (live[i] && (idx_q[i] == q_ra2)) pend2 = 1'b1;
    end
    if (q_ra1 == 5'd0) pend1 = 1'b0;
    if (q_ra2 == 5'd0) pend2 = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; occupancy alone decides
  // which slots are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (enq_store) begin
      idx_q[tail_q]  <= in_idx;
      data_q[tail_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue (DEPTH = 4): handshake, drain order,
// backpressure, wrap-around, pending flags, pipeline priority and async reset.
module tb_wb_queue;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_idx;
  logic [31:0] in_data;
  logic        pipe_we;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [4:0]  q_ra1, q_ra2;
  logic        pend1, pend2;

  int checks = 0;
  int errors = 0;

  wb_queue #(.DEPTH(4)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_idx   (in_idx),
    .in_data  (in_data),
    .pipe_we  (pipe_we),
    .rf_we    (rf_we),
    .rf_wa    (rf_wa),
    .rf_wd    (rf_wd),
    .q_ra1    (q_ra1),
    .q_ra2    (q_ra2),
    .pend1    (pend1),
    .pend2    (pend2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] idx, input logic [31:0] data);
    in_valid = 1'b1;
    in_idx   = idx;
    in_data  = data;
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_idx = '0; in_data = '0;
    pipe_we = 1'b0; q_ra1 = 5'd5; q_ra2 = 5'd0;
    #3;
    check("rst_ready", in_ready, 1);
    check("rst_we",    rf_we,    0);
    check("rst_wa",    rf_wa,    0);
    check("rst_wd",    rf_wd,    0);
    check("rst_pend1", pend1,    0);
    check("rst_pend2", pend2,    0);
    tick();
    resetn = 1'b1;

    // Single write: visible on the port one cycle after acceptance.
    push(5'd5, 32'hDEADBEEF);
    #1;
    check("single_pend_same_cycle", pend1, 0);
    check("single_we_same_cycle",   rf_we, 0);
    tick();
    in_valid = 1'b0;
    check("single_we",   rf_we, 1);
    check("single_wa",   rf_wa, 5);
    check("single_wd",   rf_wd, 32'hDEADBEEF);
    check("single_pend", pend1, 1);
    tick();
    check("single_we_after",   rf_we, 0);
    check("single_pend_after", pend1, 0);

    // Fill under pipeline starvation, then hold a fifth request.
    pipe_we = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push(5'(i), 32'h100 * i);
      #1;
      check("fill_ready", in_ready, 1);
      check("fill_no_we", rf_we, 0);
      tick();
    end
    push(5'd9, 32'h999);
    #1;
    check("full_ready", in_ready, 0);
    tick();
    check("full_ready_held", in_ready, 0);
    in_valid = 1'b0;
    pipe_we  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("bp_we", rf_we, 1);
      check("bp_wa", rf_wa, i);
      check("bp_wd", rf_wd, 32'h100 * i);
      check("bp_ready", in_ready, (i == 1) ? 0 : 1);
      tick();
    end
    check("bp_empty_we", rf_we, 0);
    check("bp_ready_after", in_ready, 1);

    // Preload 3 entries, then stream 10 writes with a drain every cycle.
    pipe_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(5'(10 + i), 32'hA000_0000 | (10 + i));
      tick();
    end
    pipe_we = 1'b0;
    for (int k = 0; k < 10; k++) begin
      push(5'(13 + k), 32'hA000_0000 | (13 + k));
      #1;
      check("stream_ready", in_ready, 1);
      check("stream_we",    rf_we, 1);
      check("stream_wa",    rf_wa, 10 + k);
      check("stream_wd",    rf_wd, 32'hA000_0000 | (10 + k));
      tick();
    end
    in_valid = 1'b0;
    for (int k = 10; k < 13; k++) begin
      #1;
      check("stream_tail_wa", rf_wa, 10 + k);
      check("stream_tail_wd", rf_wd, 32'hA000_0000 | (10 + k));
      tick();
    end
    check("stream_done_we", rf_we, 0);

    // Index 0 is swallowed; same-index writes retire in order.
    q_ra1 = 5'd0;
    q_ra2 = 5'd7;
    push(5'd0, 32'h1234);
    tick();
    in_valid = 1'b0;
    #1;
    check("x0_no_we",   rf_we, 0);
    check("x0_no_pend", pend1, 0);
    pipe_we = 1'b1;
    push(5'd7, 32'h1);
    tick();
    push(5'd7, 32'h2);
    check("same_pend_a", pend2, 1);
    tick();
    in_valid = 1'b0;
    pipe_we  = 1'b0;
    #1;
    check("same_first_wa", rf_wa, 7);
    check("same_first_wd", rf_wd, 32'h1);
    check("same_pend_b",   pend2, 1);
    tick();
    check("same_second_wd", rf_wd, 32'h2);
    check("same_pend_c",    pend2, 1);
    tick();
    check("same_pend_gone", pend2, 0);
    check("same_done_we",   rf_we, 0);

    // Pipeline priority with two entries queued.
    pipe_we = 1'b1;
    push(5'd3, 32'h33);
    tick();
    push(5'd4, 32'h44);
    tick();
    in_valid = 1'b0;
    check("prio_blocked_we", rf_we, 0);
    check("prio_blocked_wa", rf_wa, 3);
    tick();
    pipe_we = 1'b0;
    #1;
    check("prio_drain1_we", rf_we, 1);
    check("prio_drain1_wa", rf_wa, 3);
    tick();
    pipe_we = 1'b1;
    #1;
    check("prio_blocked2_we", rf_we, 0);
    check("prio_blocked2_wa", rf_wa, 4);
    tick();
    pipe_we = 1'b0;
    #1;
    check("prio_drain2_we", rf_we, 1);
    check("prio_drain2_wd", rf_wd, 32'h44);
    tick();
    check("prio_done_we", rf_we, 0);

    // Asynchronous reset between edges discards queued work.
    pipe_we = 1'b1;
    q_ra1 = 5'd2;
    for (int i = 1; i <= 3; i++) begin
      push(5'(i), 32'hB0 + i);
      tick();
    end
    in_valid = 1'b0;
    pipe_we  = 1'b0;
    #1;
    check("mid_pre_we",   rf_we, 1);
    check("mid_pre_pend", pend1, 1);
    #1;
    resetn = 1'b0;
    #1;
    check("mid_rst_we",    rf_we,    0);
    check("mid_rst_pend",  pend1,    0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_wa",    rf_wa,    0);
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("post_rst_we", rf_we, 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
